aes_block_sequencer: RTL and testbench

- Host-side initiator for aes_core: owns the core's init/next/ready/result_valid handshake and streams a job of N 128-bit blocks through it.
- Runs key expansion once per job and feeds blocks from an input stream.
- Performs CBC IV chaining between blocks and returns results on an output stream with backpressure.
- Sits between the bus/DMA front-end and aes_core.

---
 rtl/aes_seq_pkg.sv | 31 +++
 rtl/aes_seq_out_buf.sv | 31 +++
 rtl/aes_block_sequencer.sv | 143 ++++++++++++++
 tb/tb_aes_block_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the aes_core block sequencer.
package aes_seq_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_KEY_W = 256;

  localparam logic ECB = 1'b0;
  localparam logic CBC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    KINIT,
    KWAIT,
    LOAD,
    NEXT,
    BWAIT,
    OUT
  } seq_state_e;

  // Encrypt chains on the ciphertext just produced, decrypt on the ciphertext just consumed.
  function automatic logic [AES_BLK_W-1:0] chain_iv(
    input logic                 ecb_cbc,
    input logic                 encdec,
    input logic [AES_BLK_W-1:0] result,
    input logic [AES_BLK_W-1:0] block
  );
    if (ecb_cbc != CBC) return '0;
    return encdec ? result : block;
  endfunction

endpackage

// File: rtl/aes_seq_out_buf.sv
// One-entry valid/ready output register for sequencer result blocks.
module aes_seq_out_buf
  import aes_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [AES_BLK_W-1:0] load_data,
  input  logic                 load_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AES_BLK_W-1:0] m_data,
  output logic                 m_last
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_last  <= load_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_block_sequencer.sv
// Drives aes_core through a job of N blocks with CBC chaining; optional key reuse
// across jobs under AES_SEQ_KEY_CACHE_EN.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned NB_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 cfg_encdec,
  input  logic                 cfg_ecb_cbc,
  input  logic                 cfg_keylen,
  input  logic [AES_KEY_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic [NB_W-1:0]      cfg_nblk,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [AES_BLK_W-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AES_BLK_W-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic                 core_init,
  output logic                 core_next,
  output logic                 core_encdec,
  output logic                 core_ecb_cbc,
  output logic                 core_keylen,
  output logic [AES_KEY_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_iv,
  output logic [AES_BLK_W-1:0] core_block,
  input  logic                 core_ready,
  input  logic [AES_BLK_W-1:0] core_result,
  input  logic                 core_result_valid
);

  localparam logic [NB_W-1:0] ONE = NB_W'(1);

  seq_state_e      state, state_nxt;
  logic [NB_W-1:0] remaining;
  logic            job_start, zero_start, blk_done, out_hs, last_blk, cache_hit;

  assign job_start  = (state == IDLE) && start && (cfg_nblk != '0);
  assign zero_start = (state == IDLE) && start && (cfg_nblk == '0);
  assign blk_done   = (state == BWAIT) && core_ready && core_result_valid;
  assign out_hs     = (state == OUT) && m_valid && m_ready;
  assign last_blk   = (remaining == ONE);

  assign s_ready = (state == LOAD);
  assign busy    = (state != IDLE);

`ifdef AES_SEQ_KEY_CACHE_EN
  // core_key/core_keylen double as the cached key: they only change at job start,
  // and a miss at that same edge invalidates the entry until KWAIT completes.
  logic cache_valid;

  assign cache_hit = cache_valid && (cfg_key == core_key) && (cfg_keylen == core_keylen);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid <= 1'b0;
    end else if (state_nxt == KINIT) begin
      cache_valid <= 1'b0;
    end else if ((state == KWAIT) && core_ready) begin
      cache_valid <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_start) state_nxt = cache_hit ? LOAD : KINIT;
      KINIT:   state_nxt = KWAIT;
      KWAIT:   if (core_ready) state_nxt = LOAD;
      LOAD:    if (s_valid) state_nxt = NEXT;
      NEXT:    state_nxt = BWAIT;
      BWAIT:   if (core_ready && core_result_valid) state_nxt = OUT;
      OUT:     if (m_valid && m_ready) state_nxt = last_blk ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      remaining    <= '0;
      done         <= 1'b0;
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      core_encdec  <= 1'b0;
      core_ecb_cbc <= 1'b0;
      core_keylen  <= 1'b0;
      core_key     <= '0;
      core_iv      <= '0;
      core_block   <= '0;
    end else begin
      state     <= state_nxt;
      // Pulses are registered from the next state so they line up with KINIT/NEXT.
      core_init <= (state_nxt == KINIT);
      core_next <= (state_nxt == NEXT);
      done      <= zero_start || (out_hs && last_blk);

      if (job_start) begin
        core_encdec  <= cfg_encdec;
        core_ecb_cbc <= cfg_ecb_cbc;
        core_keylen  <= cfg_keylen;
        core_key     <= cfg_key;
        core_iv      <= (cfg_ecb_cbc == CBC) ? cfg_iv : '0;
        remaining    <= cfg_nblk;
      end

      if ((state == LOAD) && s_valid) begin
        core_block <= s_data;
      end

      if (blk_done) begin
        core_iv <= chain_iv(core_ecb_cbc, core_encdec, core_result, core_block);
      end

      if (out_hs) begin
        remaining <= remaining - ONE;
      end
    end
  end

  aes_seq_out_buf u_out_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (blk_done),
    .load_data (core_result),
    .load_last (last_blk),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer with a behavioural aes_core stand-in (KAT lookup
// plus an invertible toy cipher) and a job-level reference model.
module tb_aes_block_sequencer;

  localparam int unsigned NB_W = 16;

  logic            clk = 1'b0, reset_n = 1'b0;
  logic            start = 1'b0, cfg_encdec = 1'b0, cfg_ecb_cbc = 1'b0, cfg_keylen = 1'b0;
  logic [255:0]    cfg_key = '0;
  logic [127:0]    cfg_iv = '0;
  logic [NB_W-1:0] cfg_nblk = '0;
  logic            s_valid = 1'b0, s_ready;
  logic [127:0]    s_data = '0;
  logic            m_valid, m_ready = 1'b0, m_last;
  logic [127:0]    m_data;
  logic            busy, done, core_init, core_next, core_encdec, core_ecb_cbc, core_keylen;
  logic [255:0]    core_key;
  logic [127:0]    core_iv, core_block;
  logic            c_ready, c_rvalid;
  logic [127:0]    c_result;

  always #5 clk = ~clk;

  aes_block_sequencer #(.NB_W(NB_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_encdec(cfg_encdec),
    .cfg_ecb_cbc(cfg_ecb_cbc), .cfg_keylen(cfg_keylen), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .cfg_nblk(cfg_nblk), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done), .core_init(core_init),
    .core_next(core_next), .core_encdec(core_encdec), .core_ecb_cbc(core_ecb_cbc),
    .core_keylen(core_keylen), .core_key(core_key), .core_iv(core_iv),
    .core_block(core_block), .core_ready(c_ready), .core_result(c_result),
    .core_result_valid(c_rvalid)
  );

  int unsigned vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- cipher stand-in ----------------
  logic [255:0] kat_key[4];
  logic         kat_kl[4];
  logic [127:0] kat_pt[4], kat_ct[4];

  function automatic logic key_eq(input logic [255:0] a, input logic [255:0] b, input logic kl);
    return kl ? (a == b) : (a[255:128] == b[255:128]);
  endfunction

  function automatic logic [127:0] toy_kk(input logic [255:0] k, input logic kl);
    return kl ? (k[255:128] ^ k[127:0]) : k[255:128];
  endfunction

  function automatic logic [127:0] aes_e(input logic [255:0] k, input logic kl, input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 4; i++)
      if (kat_kl[i] == kl && key_eq(k, kat_key[i], kl) && kat_pt[i] == x) return kat_ct[i];
    y = x ^ toy_kk(k, kl);
    return {y[114:0], y[127:115]};
  endfunction

  function automatic logic [127:0] aes_d(input logic [255:0] k, input logic kl, input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 4; i++)
      if (kat_kl[i] == kl && key_eq(k, kat_key[i], kl) && kat_ct[i] == x) return kat_pt[i];
    y = {x[12:0], x[127:13]};
    return y ^ toy_kk(k, kl);
  endfunction

  // ---------------- aes_core behavioural model ----------------
  logic [255:0] c_key = '0;
  logic         c_kl = 1'b0, c_is_next = 1'b0, c_vpend = 1'b0;
  int           c_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_ready <= 1'b1; c_rvalid <= 1'b0; c_result <= '0;
      c_cnt <= 0; c_vpend <= 1'b0; c_is_next <= 1'b0;
    end else begin
      c_vpend <= 1'b0;
      if (c_vpend) c_rvalid <= 1'b1;
      if (core_init || core_next) begin
        c_ready   <= 1'b0;
        c_cnt     <= int'($urandom_range(2, 8));
        c_is_next <= core_next;
        if (core_init) begin c_key <= core_key; c_kl <= core_keylen; end
      end else if (c_cnt > 0) begin
        c_rvalid <= 1'b0;
        c_cnt    <= c_cnt - 1;
        if (c_cnt == 1) begin
          c_ready <= 1'b1;
          if (c_is_next) begin
            c_result <= core_encdec ?
                        aes_e(c_key, c_kl, core_ecb_cbc ? (core_block ^ core_iv) : core_block) :
                        (aes_d(c_key, c_kl, core_block) ^ (core_ecb_cbc ? core_iv : 128'h0));
            c_vpend <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- job reference model and stream driver ----------------
  typedef struct packed { logic [127:0] d; logic l; } exp_t;
  logic [127:0] in_q[$];
  exp_t         exp_q[$];
  exp_t         e_cur;
  logic         in_take = 1'b0, bp_hold = 1'b0, prev_init = 1'b0, prev_next = 1'b0;
  int unsigned  init_cnt = 0, next_cnt = 0;

  task automatic ref_job(input logic enc, input logic cbc, input logic kl, input logic [255:0] key,
                         input logic [127:0] iv, input int unsigned n);
    logic [127:0] ch, p, o;
    ch = iv;
    for (int unsigned i = 0; i < n; i++) begin
      p = in_q[i];
      if (!cbc) o = enc ? aes_e(key, kl, p) : aes_d(key, kl, p);
      else if (enc) begin o = aes_e(key, kl, p ^ ch); ch = o; end
      else begin o = aes_d(key, kl, p) ^ ch; ch = p; end
      exp_q.push_back('{d: o, l: (i == n - 1)});
    end
  endtask

  always begin
    @(negedge clk);
    in_take = s_valid && s_ready;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 128'(1), 128'(0));
      else begin
        e_cur = exp_q.pop_front();
        check("m_data", m_data, e_cur.d);
        check("m_last", 128'(m_last), 128'(e_cur.l));
      end
    end
    if (core_init) begin init_cnt++; check("core_init_width", 128'(prev_init), 128'(0)); end
    if (core_next) begin
      next_cnt++;
      check("core_next_width", 128'(prev_next), 128'(0));
      if (!core_ecb_cbc) check("ecb_iv_zero", core_iv, 128'h0);
    end
    prev_init = core_init;
    prev_next = core_next;
    @(posedge clk); #1;
    if (in_take && in_q.size() > 0) void'(in_q.pop_front());
    s_valid = (in_q.size() != 0) && ($urandom_range(0, 3) != 0);
    s_data  = (in_q.size() != 0) ? in_q[0] : 128'h0;
    m_ready = !bp_hold && ($urandom_range(0, 2) != 0);
    if (busy) begin
      cfg_encdec = 1'($urandom); cfg_ecb_cbc = 1'($urandom); cfg_keylen = 1'($urandom);
      cfg_key = {8{$urandom}}; cfg_iv = {4{$urandom}}; cfg_nblk = NB_W'($urandom);
    end
  end

  logic         cache_ok = 1'b0, last_kl = 1'b0;
  logic [255:0] last_key = '0;

  task automatic run_job(input logic enc, input logic cbc, input logic kl, input logic [255:0] key,
                         input logic [127:0] iv, input int unsigned n);
    int unsigned i0, ei;
    logic got;
    i0 = init_cnt;
    ei = (n == 0) ? 0 : 1;
`ifdef AES_SEQ_KEY_CACHE_EN
    if (n != 0 && cache_ok && key == last_key && kl == last_kl) ei = 0;
`endif
    @(posedge clk); #1;
    cfg_encdec = enc; cfg_ecb_cbc = cbc; cfg_keylen = kl; cfg_key = key; cfg_iv = iv;
    cfg_nblk = NB_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("job_done", 128'(got), 128'(1));
    check("outputs_pending", 128'(exp_q.size()), 128'(0));
    check("init_count", 128'(init_cnt - i0), 128'(ei));
    @(negedge clk);
    check("done_width", 128'(done), 128'(0));
    if (n != 0) begin cache_ok = 1'b1; last_key = key; last_kl = kl; end
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic rand_job(input logic [255:0] key, input logic kl, input int unsigned n);
    logic enc, cbc;
    logic [127:0] iv;
    enc = 1'($urandom); cbc = 1'($urandom); iv = {4{$urandom}};
    for (int unsigned i = 0; i < n; i++) in_q.push_back({4{$urandom}});
    ref_job(enc, cbc, kl, key, iv, n);
    run_job(enc, cbc, kl, key, iv, n);
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    logic enc, cbc, kl;
    logic [255:0] key;
    logic [127:0] iv;
    int unsigned n;
    logic [127:0] pt0, pt1, ct0, ct1;
  } vec_t;
  vec_t vt[5];

  initial begin
    logic [255:0] k128, k256, kcbc, ka, kb, kr;
    logic [127:0] iv0, p1, p2, c1, c2, pa, ca, cb, d0;
    logic kr_l, got;
    int unsigned i0, nx0;

    k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    kcbc = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    iv0 = 128'h000102030405060708090a0b0c0d0e0f;
    pa  = 128'h00112233445566778899aabbccddeeff;
    ca  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    cb  = 128'h8ea2b7ca516745bfeafc49904b496089;
    p1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    p2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    c1  = 128'h7649abac8119b246cee98e9b12e9197d;
    c2  = 128'h5086cb9b507219ee95db113a917678b2;
    kat_key[0] = k128; kat_kl[0] = 1'b0; kat_pt[0] = pa;      kat_ct[0] = ca;
    kat_key[1] = k256; kat_kl[1] = 1'b1; kat_pt[1] = pa;      kat_ct[1] = cb;
    kat_key[2] = kcbc; kat_kl[2] = 1'b0; kat_pt[2] = p1 ^ iv0; kat_ct[2] = c1;
    kat_key[3] = kcbc; kat_kl[3] = 1'b0; kat_pt[3] = p2 ^ c1;  kat_ct[3] = c2;

    vt[0] = '{enc: 1, cbc: 0, kl: 0, key: k128, iv: 0,   n: 1, pt0: pa, pt1: 0,  ct0: ca, ct1: 0};
    vt[1] = '{enc: 1, cbc: 0, kl: 1, key: k256, iv: 0,   n: 1, pt0: pa, pt1: 0,  ct0: cb, ct1: 0};
    vt[2] = '{enc: 1, cbc: 1, kl: 0, key: kcbc, iv: iv0, n: 2, pt0: p1, pt1: p2, ct0: c1, ct1: c2};
    vt[3] = '{enc: 0, cbc: 1, kl: 0, key: kcbc, iv: iv0, n: 2, pt0: c1, pt1: c2, ct0: p1, ct1: p2};
    vt[4] = '{enc: 0, cbc: 0, kl: 0, key: k128, iv: 0,   n: 1, pt0: ca, pt1: 0,  ct0: pa, ct1: 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 128'({m_valid, s_ready, m_last, busy, done, core_init, core_next,
                            core_encdec, core_ecb_cbc, core_keylen}), 128'(0));
    check("rst_m_data", m_data, 128'h0);
    check("rst_key_hi", core_key[255:128], 128'h0);
    check("rst_key_lo", core_key[127:0], 128'h0);
    check("rst_iv", core_iv, 128'h0);
    check("rst_block", core_block, 128'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Known-answer vectors
    for (int i = 0; i < 5; i++) begin
      in_q.push_back(vt[i].pt0);
      exp_q.push_back('{d: vt[i].ct0, l: (vt[i].n == 1)});
      if (vt[i].n == 2) begin
        in_q.push_back(vt[i].pt1);
        exp_q.push_back('{d: vt[i].ct1, l: 1'b1});
      end
      run_job(vt[i].enc, vt[i].cbc, vt[i].kl, vt[i].key, vt[i].iv, vt[i].n);
    end

    // Randomised jobs, sometimes reusing the previous key
    kr = {8{$urandom}}; kr_l = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if ($urandom_range(0, 2) != 0) begin kr = {8{$urandom}}; kr_l = 1'($urandom); end
      rand_job(kr, kr_l, $urandom_range(1, 6));
    end

    // Backpressure on block 1 of a 3-block job, with a stray start mid-job
    for (int unsigned i = 0; i < 3; i++) in_q.push_back({4{$urandom}});
    kr = {8{$urandom}};
    ref_job(1'b1, 1'b1, 1'b1, kr, 128'h5a5a, 3);
    bp_hold = 1'b1;
    fork
      run_job(1'b1, 1'b1, 1'b1, kr, 128'h5a5a, 3);
      begin
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk);
          if (m_valid) begin got = 1'b1; break; end
        end
        check("bp_m_valid_seen", 128'(got), 128'(1));
        d0 = m_data; nx0 = next_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 18; c++) begin
          @(negedge clk);
          check("bp_m_data_stable", m_data, d0);
          check("bp_flags", 128'({m_valid, s_ready}), 128'(2'b10));
        end
        check("bp_no_core_next", 128'(next_cnt), 128'(nx0));
        bp_hold = 1'b0;
      end
    join

    // Zero-length job
    i0 = init_cnt;
    @(posedge clk); #1;
    cfg_nblk = '0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("nblk0_done", 128'({done, busy}), 128'(2'b10));
    @(negedge clk);
    check("nblk0_done_width", 128'(done), 128'(0));
    check("nblk0_no_init", 128'(init_cnt), 128'(i0));

    // Reset while waiting on a block result
    for (int unsigned i = 0; i < 2; i++) in_q.push_back({4{$urandom}});
    @(posedge clk); #1;
    cfg_encdec = 1'b1; cfg_ecb_cbc = 1'b1; cfg_keylen = 1'b0; cfg_key = {8{$urandom}};
    cfg_iv = {4{$urandom}}; cfg_nblk = NB_W'(2); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (core_next) begin got = 1'b1; break; end
    end
    check("bwait_reached", 128'(got), 128'(1));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", 128'({m_valid, s_ready, m_last, busy, done, core_init, core_next,
                               core_encdec, core_ecb_cbc, core_keylen}), 128'(0));
    check("midrst_m_data", m_data, 128'h0);
    check("midrst_iv", core_iv, 128'h0);
    check("midrst_block", core_block, 128'h0);
    check("midrst_key", core_key[255:128], 128'h0);
    in_q.delete();
    exp_q.delete();
    cache_ok = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 128'({done, busy, m_valid}), 128'(0));
    rand_job({8{$urandom}}, 1'b1, 3);

    // Key reuse across back-to-back jobs
    ka = {8{$urandom}}; kb = {8{$urandom}};
    i0 = init_cnt;
    rand_job(ka, 1'b0, 2);
    rand_job(ka, 1'b0, 1);
`ifdef AES_SEQ_KEY_CACHE_EN
    check("cache_two_jobs_inits", 128'(init_cnt - i0), 128'(1));
`else
    check("cache_two_jobs_inits", 128'(init_cnt - i0), 128'(2));
`endif
    rand_job(kb, 1'b0, 2);
`ifdef AES_SEQ_KEY_CACHE_EN
    check("cache_new_key_inits", 128'(init_cnt - i0), 128'(2));
`else
    check("cache_new_key_inits", 128'(init_cnt - i0), 128'(3));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
